// File: rtl/sample_iter_if.sv
// Bbox-to-sample-test handshake bundle for sample_iter_ctrl.
// SAMPLE_ITER_CNT_EN adds the per-triangle consumed-sample count.
interface sample_iter_if #(
  parameter int unsigned SIGFIG = 24,
  parameter int unsigned VERTS  = 3,
  parameter int unsigned AXIS   = 3,
  parameter int unsigned COLORS = 3
);
  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S;
  logic        [COLORS-1:0][SIGFIG-1:0]          color_R13U;
  logic signed [1:0][1:0][SIGFIG-1:0]            box_R13S;
  logic                                          validTri_R13H;
  logic                                          halt_RnnnnL;
  logic        [3:0]                             subSample_RnnnnU;
  logic                                          sampReady_R14H;
  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
  logic        [COLORS-1:0][SIGFIG-1:0]          color_R14U;
  logic signed [1:0][SIGFIG-1:0]                 sample_R14S;
  logic                                          validSamp_R14H;
`ifdef SAMPLE_ITER_CNT_EN
  logic        [31:0]                            sampCnt_R14U;
`endif

  // Controller side
  modport slave (
`ifdef SAMPLE_ITER_CNT_EN
    output sampCnt_R14U,
`endif
    input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU, sampReady_R14H,
    output halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
  );

  // Bbox / sample-test side
  modport master (
`ifdef SAMPLE_ITER_CNT_EN
    input  sampCnt_R14U,
`endif
    output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU, sampReady_R14H,
    input  halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
  );
endinterface

// File: rtl/sample_iter_ctrl.sv
// Walks a grid-snapped bounding box in raster order at the subsample pitch.
// Define SAMPLE_ITER_CNT_EN to add the sampCnt_R14U consumed-sample counter.
module sample_iter_ctrl #(
  parameter int unsigned SIGFIG = 24,
  parameter int unsigned RADIX  = 10,
  parameter int unsigned VERTS  = 3,
  parameter int unsigned AXIS   = 3,
  parameter int unsigned COLORS = 3
) (
  input  logic          clk,
  input  logic          rst,
  sample_iter_if.slave  bus
);
  localparam int unsigned EW = SIGFIG + 1;

  typedef enum logic {S_WAIT = 1'b0, S_ITER = 1'b1} state_t;

  state_t state_q, state_d;

  logic        [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q;
  logic        [COLORS-1:0][SIGFIG-1:0]          color_q;
  logic signed [EW-1:0]                          ll_x_q, ll_y_q, ur_x_q, ur_y_q, step_q;
  logic        [1:0][SIGFIG-1:0]                 sample_q, sample_d;
  logic                                          valid_q, valid_d, ld_d;
`ifdef SAMPLE_ITER_CNT_EN
  logic        [31:0]                            cnt_q;
`endif

  logic signed [EW-1:0] in_ll_x, in_ll_y, in_ur_x, in_ur_y, step_in;
  logic signed [EW-1:0] cur_x, cur_y, nx, ny;
  logic        [1:0]    ss_lg;
  logic                 inv_in, x_ok, y_ok;

  // Incoming box widened one bit so signed compares and +step never wrap
  always_comb begin
    in_ll_x = EW'($signed(bus.box_R13S[0][0]));
    in_ll_y = EW'($signed(bus.box_R13S[0][1]));
    in_ur_x = EW'($signed(bus.box_R13S[1][0]));
    in_ur_y = EW'($signed(bus.box_R13S[1][1]));
    inv_in  = (in_ll_x > in_ur_x) || (in_ll_y > in_ur_y);
    ss_lg   = 2'd0;
    if (bus.subSample_RnnnnU[0])      ss_lg = 2'd3;
    else if (bus.subSample_RnnnnU[1]) ss_lg = 2'd2;
    else if (bus.subSample_RnnnnU[2]) ss_lg = 2'd1;
    step_in = EW'(1) << (RADIX - 32'(ss_lg));
  end

  // Raster advance candidates from the latched box and step
  always_comb begin
    cur_x = EW'($signed(sample_q[0]));
    cur_y = EW'($signed(sample_q[1]));
    nx    = cur_x + step_q;
    ny    = cur_y + step_q;
    x_ok  = (nx <= ur_x_q);
    y_ok  = (ny <= ur_y_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_WAIT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:  if (bus.validTri_R13H && !inv_in) state_d = S_ITER;
      S_ITER:  if (bus.sampReady_R14H && !x_ok && !y_ok) state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase
  end

  always_comb begin
    ld_d     = 1'b0;
    sample_d = sample_q;
    valid_d  = valid_q;
    bus.halt_RnnnnL = (state_q == S_WAIT);
    case (state_q)
      S_WAIT: begin
        valid_d = 1'b0;
        if (bus.validTri_R13H) begin
          ld_d = 1'b1;
          if (!inv_in) begin
            sample_d[0] = SIGFIG'(in_ll_x);
            sample_d[1] = SIGFIG'(in_ll_y);
            valid_d     = 1'b1;
          end
        end
      end
      S_ITER: begin
        if (bus.sampReady_R14H) begin
          if (x_ok) begin
            sample_d[0] = SIGFIG'(nx);
          end else if (y_ok) begin
            sample_d[0] = SIGFIG'(ll_x_q);
            sample_d[1] = SIGFIG'(ny);
          end else begin
            valid_d = 1'b0;
          end
        end
      end
      default: valid_d = 1'b0;
    endcase
  end

  // Datapath registers; box and step are frozen for the whole triangle
  always_ff @(posedge clk) begin
    if (!rst) begin
      tri_q    <= '0;
      color_q  <= '0;
      ll_x_q   <= '0;
      ll_y_q   <= '0;
      ur_x_q   <= '0;
      ur_y_q   <= '0;
      step_q   <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (ld_d) begin
        tri_q   <= bus.tri_R13S;
        color_q <= bus.color_R13U;
        ll_x_q  <= in_ll_x;
        ll_y_q  <= in_ll_y;
        ur_x_q  <= in_ur_x;
        ur_y_q  <= in_ur_y;
        step_q  <= step_in;
      end
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

`ifdef SAMPLE_ITER_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst)                                  cnt_q <= '0;
    else if (ld_d)                             cnt_q <= '0;
    else if (valid_q && bus.sampReady_R14H)    cnt_q <= cnt_q + 32'd1;
  end
  assign bus.sampCnt_R14U = cnt_q;
`endif

  assign bus.tri_R14S       = tri_q;
  assign bus.color_R14U     = color_q;
  assign bus.sample_R14S    = sample_q;
  assign bus.validSamp_R14H = valid_q;
endmodule

// File: tb/tb_sample_iter_ctrl.sv
// Randomized bench for sample_iter_ctrl against a nested-loop sample-list model.
module tb_sample_iter_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [47:0] exp_q[$];

  always #5 clk = ~clk;

  sample_iter_if #(.SIGFIG(24), .VERTS(3), .AXIS(3), .COLORS(3)) bus ();

  sample_iter_ctrl #(.SIGFIG(24), .RADIX(10), .VERTS(3), .AXIS(3), .COLORS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected sample list straight from the raster-order definition
  task automatic build_exp(input int llx, input int lly, input int urx, input int ury, input int step);
    exp_q.delete();
    for (int y = lly; y <= ury; y += step)
      for (int x = llx; x <= urx; x += step)
        exp_q.push_back({24'(y), 24'(x)});
  endtask

  task automatic check_reset_outputs();
    check_val("rst_valid", 256'(bus.validSamp_R14H), 256'(0));
    check_val("rst_halt", 256'(bus.halt_RnnnnL), 256'(1));
    check_val("rst_sample", 256'($unsigned(bus.sample_R14S)), 256'(0));
    check_val("rst_tri", 256'($unsigned(bus.tri_R14S)), 256'(0));
    check_val("rst_color", 256'(bus.color_R14U), 256'(0));
`ifdef SAMPLE_ITER_CNT_EN
    check_val("rst_cnt", 256'(bus.sampCnt_R14U), 256'(0));
`endif
  endtask

  // mode 0: always ready, 1: random ready, 2: 3-cycle stall on 2nd sample, 3: reset on 3rd sample
  task automatic run_tri(input int llx, input int lly, input int urx, input int ury,
                         input int k, input int mode);
    int step, guard, idx, stall, total;
    logic rdy, did_rst;
    logic [215:0] tv;
    logic [71:0]  cv;
    step = 1 << (7 + k);
    for (int i = 0; i < 216; i++) tv[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < 72; i++)  cv[i] = 1'($urandom_range(0, 1));
    guard = 0;
    while (!bus.halt_RnnnnL && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_val("pre_halt", 256'(bus.halt_RnnnnL), 256'(1));
    bus.validTri_R13H    = 1'b1;
    bus.box_R13S[0][0]   = 24'(llx);
    bus.box_R13S[0][1]   = 24'(lly);
    bus.box_R13S[1][0]   = 24'(urx);
    bus.box_R13S[1][1]   = 24'(ury);
    bus.subSample_RnnnnU = 4'(1 << k);
    bus.tri_R13S         = tv;
    bus.color_R13U       = cv;
    @(posedge clk);
    @(negedge clk);
    // Inputs after accept must have no effect on this triangle
    bus.validTri_R13H    = 1'b0;
    bus.subSample_RnnnnU = 4'(1 << $urandom_range(0, 3));
    bus.box_R13S         = '0;
    bus.tri_R13S         = '0;
    build_exp(llx, lly, urx, ury, step);
    total = exp_q.size();
    if (total != 0) begin
      check_val("tri_latch", 256'($unsigned(bus.tri_R14S)), 256'(tv));
      check_val("color_latch", 256'(bus.color_R14U), 256'(cv));
    end
    idx = 0; stall = 0; guard = 0; did_rst = 1'b0;
    while (exp_q.size() > 0 && guard < 4000 && !did_rst) begin
      check_val("valid", 256'(bus.validSamp_R14H), 256'(1));
      check_val("halt_busy", 256'(bus.halt_RnnnnL), 256'(0));
      check_val("sample", 256'($unsigned(bus.sample_R14S)), 256'(exp_q[0]));
      case (mode)
        1:       rdy = 1'($urandom_range(0, 1));
        2:       rdy = !(idx == 1 && stall < 3);
        default: rdy = 1'b1;
      endcase
      if (!rdy) stall++;
      bus.sampReady_R14H = rdy;
      if (mode == 3 && idx == 2) rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (mode == 3 && idx == 2) begin
        did_rst = 1'b1;
        rst = 1'b1;
      end
      if (rdy) begin
        void'(exp_q.pop_front());
        idx++;
      end
      guard++;
    end
    bus.sampReady_R14H = 1'b0;
    if (did_rst) begin
      check_reset_outputs();
      @(negedge clk);
      check_val("post_rst_valid", 256'(bus.validSamp_R14H), 256'(0));
      exp_q.delete();
    end else begin
      check_val("drained", 256'(exp_q.size()), 256'(0));
      check_val("end_valid", 256'(bus.validSamp_R14H), 256'(0));
      check_val("end_halt", 256'(bus.halt_RnnnnL), 256'(1));
`ifdef SAMPLE_ITER_CNT_EN
      check_val("samp_cnt", 256'(bus.sampCnt_R14U), 256'(total));
`endif
    end
  endtask

  initial begin
    int k, step, llx, lly, urx, ury;
    rst = 1'b0;
    bus.tri_R13S = '0;
    bus.color_R13U = '0;
    bus.box_R13S = '0;
    bus.validTri_R13H = 1'b0;
    bus.subSample_RnnnnU = 4'b1000;
    bus.sampReady_R14H = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b1;
    @(negedge clk);

    run_tri(0, 0, 1024, 1024, 3, 0);
    run_tri(256, 512, 384, 512, 0, 0);
    run_tri(2048, 2048, 2048, 2048, 3, 1);
    run_tri(3072, 0, 2048, 0, 3, 0);
    run_tri(0, 0, 1024, 1024, 3, 2);
    run_tri(0, 0, 1024, 1024, 3, 3);
    run_tri(0, 0, 1024, 1024, 2, 0);
    run_tri(32'h7FF800, -1024, 32'h7FFC00, 0, 3, 1);
    run_tri(-2048, -1024, -1024, -1024, 1, 0);

    for (int t = 0; t < 40; t++) begin
      k    = int'($urandom_range(0, 3));
      step = 1 << (7 + k);
      llx  = int'($urandom_range(0, 64)) * 128 - 4096;
      lly  = int'($urandom_range(0, 64)) * 128 - 4096;
      urx  = llx + int'($urandom_range(0, 4)) * step + int'($urandom_range(0, 1)) * 128;
      ury  = lly + int'($urandom_range(0, 4)) * step + int'($urandom_range(0, 1)) * 128;
      if ($urandom_range(0, 7) == 0) urx = llx - 128;
      if ($urandom_range(0, 7) == 0) ury = lly - 128;
      run_tri(llx, lly, urx, ury, k, int'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
